// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester command/response bus plus the shared ALU operand/result bus.
interface alu_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 2
);
    logic [1:0]       REQ_VALID;
    logic [1:0]       REQ_READY;
    logic [2:0]       REQ_OP0, REQ_OP1;
    logic [WIDTH-1:0] REQ_A0, REQ_A1;
    logic [WIDTH-1:0] REQ_B0, REQ_B1;
    logic [TAG_W-1:0] REQ_TAG0, REQ_TAG1;
    logic [1:0]       RSP_VALID;
    logic [1:0]       RSP_READY;
    logic [WIDTH-1:0] RSP_DATA;
    logic [TAG_W-1:0] RSP_TAG;
    logic             RSP_ERR;
    logic [WIDTH-1:0] ALU_A, ALU_B;
    logic             ALU_L, ALU_M, ALU_N;
    logic [WIDTH-1:0] ALU_S;
    modport slave (
        input  REQ_VALID, REQ_OP0, REQ_OP1, REQ_A0, REQ_A1, REQ_B0, REQ_B1,
               REQ_TAG0, REQ_TAG1, RSP_READY, ALU_S,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_TAG, RSP_ERR,
               ALU_A, ALU_B, ALU_L, ALU_M, ALU_N
    );
    modport master (
        output REQ_VALID, REQ_OP0, REQ_OP1, REQ_A0, REQ_A1, REQ_B0, REQ_B1,
               REQ_TAG0, REQ_TAG1, RSP_READY, ALU_S,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_TAG, RSP_ERR,
               ALU_A, ALU_B, ALU_L, ALU_M, ALU_N
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two requesters,
// one command in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 2
) (
    input  logic          CLK,
    input  logic          RESET_N,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           r_state, w_next;
    logic             r_ptr, r_port, r_err;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_data;
    logic [TAG_W-1:0] r_tag;
    logic             w_gnt_port, w_accept, w_illegal;
    assign w_gnt_port = &bus.REQ_VALID ? r_ptr : bus.REQ_VALID[1];
    assign w_accept   = RESET_N && r_state == IDLE && |bus.REQ_VALID;
    assign w_illegal  = &r_op;
    assign bus.REQ_READY = w_accept ? (w_gnt_port ? 2'b10 : 2'b01) : 2'b00;
    assign bus.RSP_DATA  = r_data;
    assign bus.RSP_TAG   = r_tag;
    assign bus.RSP_ERR   = r_err;
    assign bus.ALU_A     = r_a;
    assign bus.ALU_B     = r_b;
    // the reserved opcode runs the ALU as a harmless ADD; its result is discarded
    assign {bus.ALU_L, bus.ALU_M, bus.ALU_N} = w_illegal ? 3'b010 : r_op;
    always_ff @(posedge CLK) begin
        if (!RESET_N)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next        = r_state;
        bus.RSP_VALID = 2'b00;
        case (r_state)
            IDLE: w_next = w_accept ? EXEC : IDLE;
            EXEC: w_next = RESP;
            RESP: begin
                bus.RSP_VALID = r_port ? 2'b10 : 2'b01;
                w_next        = bus.RSP_READY[r_port] ? IDLE : RESP;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_ptr  <= 1'b0;
            r_port <= 1'b0;
            r_op   <= 3'b010;
            r_a    <= '0;
            r_b    <= '0;
            r_tag  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_port <= w_gnt_port;
                r_ptr  <= ~w_gnt_port;
                r_op   <= w_gnt_port ? bus.REQ_OP1 : bus.REQ_OP0;
                r_a    <= w_gnt_port ? bus.REQ_A1 : bus.REQ_A0;
                r_b    <= w_gnt_port ? bus.REQ_B1 : bus.REQ_B0;
                r_tag  <= w_gnt_port ? bus.REQ_TAG1 : bus.REQ_TAG0;
            end
            if (r_state == EXEC) begin
                r_data <= w_illegal ? '0 : bus.ALU_S;
                r_err  <= w_illegal;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed traffic on both ports; a cycle-level reference model and
// per-port scoreboards check handshakes, arbitration, latency, ALU drive and responses.
module tb_alu_arbiter;
    localparam int W = 4;
    localparam int T = 2;
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [T-1:0] tag;
        int           hold;
        bit           must;
        int           gap;
    } cmd_t;
    typedef struct {
        logic [W-1:0] data;
        logic [T-1:0] tag;
        logic         err;
    } rsp_t;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;
    alu_arbiter_if #(.WIDTH(W), .TAG_W(T)) bus();
    alu_arbiter #(.WIDTH(W), .TAG_W(T)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus.slave));
    logic         s_v[2];
    logic [2:0]   s_op[2];
    logic [W-1:0] s_a[2], s_b[2];
    logic [T-1:0] s_tag[2];
    logic [1:0]   s_rr = 2'b11;
    logic [1:0]   rr_force = 2'b11;
    bit           rr_rand = 0;
    int total = 0;
    int bad = 0;
    cmd_t cq[2][$];
    rsp_t exp_q[2][$];
    bit   d_busy[2];
    assign bus.REQ_VALID = {s_v[1], s_v[0]};
    assign bus.REQ_OP0 = s_op[0];
    assign bus.REQ_OP1 = s_op[1];
    assign bus.REQ_A0 = s_a[0];
    assign bus.REQ_A1 = s_a[1];
    assign bus.REQ_B0 = s_b[0];
    assign bus.REQ_B1 = s_b[1];
    assign bus.REQ_TAG0 = s_tag[0];
    assign bus.REQ_TAG1 = s_tag[1];
    assign bus.RSP_READY = s_rr;
    // Reference arithmetic: results modulo 2^W, reserved opcode yields 0
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x, y, r;
        x = a;
        y = b;
        case (op)
            3'd0: r = 0 - x;
            3'd1: r = 0 - y;
            3'd2: r = x + y;
            3'd3: r = x - y;
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x * y;
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction
    // Stand-in ALU; the reserved code returns junk so an unforced opcode would show
    logic [2:0] alu_lmn;
    assign alu_lmn = {bus.ALU_L, bus.ALU_M, bus.ALU_N};
    assign bus.ALU_S = (alu_lmn == 3'd7) ? W'(10) : ref_result(alu_lmn, bus.ALU_A, bus.ALU_B);
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask
    task automatic drive_port(input int p);
        cmd_t c;
        rsp_t r;
        bit   acc;
        forever begin
            @(posedge CLK);
            #1;
            if (cq[p].size() != 0) begin
                c = cq[p].pop_front();
                d_busy[p] = 1;
                repeat (c.gap) begin
                    @(posedge CLK);
                    #1;
                end
                s_op[p] = c.op;
                s_a[p] = c.a;
                s_b[p] = c.b;
                s_tag[p] = c.tag;
                s_v[p] = 1'b1;
                acc = 0;
                for (int i = 0; i < c.hold && !acc; i++) begin
                    @(negedge CLK);
                    if (bus.REQ_READY[p]) begin
                        acc = 1;
                        r.data = ref_result(c.op, c.a, c.b);
                        r.tag = c.tag;
                        r.err = (c.op == 3'd7);
                        exp_q[p].push_back(r);
                    end
                    @(posedge CLK);
                    #1;
                end
                s_v[p] = 1'b0;
                if (!acc && c.must) fail("accept_timeout");
                d_busy[p] = 0;
            end
        end
    endtask
    initial forever begin
        @(posedge CLK);
        #1;
        s_rr = rr_rand ? 2'($urandom) : rr_force;
    end
    // Monitor: m_* is the expected DUT situation after the most recent clock edge
    bit           m_busy = 0, m_port = 0, m_ptr = 0, m_rst = 1;
    int           m_age = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [2:0]   m_lmn = 3'd2;
    always @(negedge CLK) begin : mon
        logic [1:0] er, ev, vld;
        logic [2:0] op;
        rsp_t       f;
        vld = bus.REQ_VALID;
        er = (RESET_N && !m_busy) ? ((vld == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : vld) : 2'b00;
        ev = (m_busy && m_age >= 2) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
        check("req_ready", bus.REQ_READY, er);
        check("rsp_valid", bus.RSP_VALID, ev);
        check("alu_a", bus.ALU_A, m_a);
        check("alu_b", bus.ALU_B, m_b);
        check("alu_lmn", alu_lmn, m_lmn);
        if (ev != 2'b00) begin
            if (exp_q[m_port].size() == 0) begin
                fail("scoreboard_empty");
            end else begin
                f = exp_q[m_port][0];
                check("rsp_data", bus.RSP_DATA, f.data);
                check("rsp_tag", bus.RSP_TAG, f.tag);
                check("rsp_err", bus.RSP_ERR, f.err);
            end
        end
        if (m_rst) begin
            check("rst_data", bus.RSP_DATA, 0);
            check("rst_tag", bus.RSP_TAG, 0);
            check("rst_err", bus.RSP_ERR, 0);
        end
        if (!RESET_N) begin
            m_busy = 0; m_port = 0; m_ptr = 0; m_rst = 1; m_age = 0;
            m_a = '0; m_b = '0; m_lmn = 3'd2;
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            m_rst = 0;
            if (ev != 2'b00 && bus.RSP_READY[m_port]) begin
                m_busy = 0;
                if (exp_q[m_port].size() != 0) f = exp_q[m_port].pop_front();
            end else if (m_busy) begin
                m_age++;
            end else if (er != 2'b00) begin
                m_port = er[1];
                m_ptr = !er[1];
                m_busy = 1;
                m_age = 1;
                m_a = er[1] ? bus.REQ_A1 : bus.REQ_A0;
                m_b = er[1] ? bus.REQ_B1 : bus.REQ_B0;
                op = er[1] ? bus.REQ_OP1 : bus.REQ_OP0;
                m_lmn = (op == 3'd7) ? 3'd2 : op;
            end
        end
    end
    task automatic add(input int p, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [T-1:0] tag);
        cmd_t c;
        c.op = op; c.a = a; c.b = b; c.tag = tag; c.hold = 50; c.must = 1; c.gap = 0;
        cq[p].push_back(c);
    endtask
    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (cq[0].size() == 0 && cq[1].size() == 0 && !d_busy[0] && !d_busy[1]
                && exp_q[0].size() == 0 && exp_q[1].size() == 0) return;
        end
        fail("drain_timeout");
    endtask
    task automatic wait_rsp(input int p);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (bus.RSP_VALID[p]) return;
        end
        fail("rsp_timeout");
    endtask
    task automatic do_reset();
        @(posedge CLK);
        #1 RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(negedge CLK);
    endtask
    initial begin
        cmd_t c;
        s_v = '{1'b0, 1'b0};
        s_op = '{3'd0, 3'd0};
        s_a = '{'0, '0};
        s_b = '{'0, '0};
        s_tag = '{'0, '0};
        d_busy = '{0, 0};
        fork
            drive_port(0);
            drive_port(1);
        join_none
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(negedge CLK);
        add(0, 3'd2, 4'd5, 4'd3, 2'd1);
        drain(100);
        do_reset();
        add(0, 3'd3, 4'd2, 4'd5, 2'd0);
        add(0, 3'd3, 4'd2, 4'd5, 2'd1);
        add(1, 3'd6, 4'd3, 4'd6, 2'd2);
        add(1, 3'd6, 4'd3, 4'd6, 2'd3);
        drain(200);
        rr_force = 2'b01;
        add(1, 3'd1, 4'd0, 4'd1, 2'd3);
        wait_rsp(1);
        repeat (6) @(posedge CLK);
        rr_force = 2'b11;
        drain(100);
        @(negedge CLK);
        add(0, 3'd7, 4'd7, 4'd7, 2'd2);
        drain(100);
        rr_force = 2'b00;
        @(negedge CLK);
        add(0, 3'd4, 4'd13, 4'd11, 2'd1);
        wait_rsp(0);
        @(posedge CLK);
        #1 RESET_N = 1'b0;
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        rr_force = 2'b11;
        @(negedge CLK);
        add(0, 3'd2, 4'd1, 4'd1, 2'd0);
        add(1, 3'd2, 4'd2, 4'd2, 2'd1);
        drain(200);
        for (int k = 0; k < 7; k++) add(0, 3'(k), 4'd12, 4'd10, 2'(k));
        drain(300);
        rr_rand = 1;
        for (int k = 0; k < 80; k++) begin
            c.op = 3'($urandom_range(0, 7));
            c.a = W'($urandom);
            c.b = W'($urandom);
            c.tag = T'($urandom);
            c.hold = $urandom_range(1, 6);
            c.must = 0;
            c.gap = $urandom_range(0, 3);
            cq[k % 2].push_back(c);
        end
        drain(5000);
        rr_rand = 0;
        drain(100);
        repeat (3) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
